// File: rtl/loop_sched_pkg.sv
// Shared types and constants for the control-loop scheduler.
// Holds the sequencer state encoding and the default stage timeout.
package loop_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    COMPUTE,
    APPLY,
    LOG
  } state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 100000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/loop_scheduler_stage_timer.sv
// Loadable down-counter guarding the SAMPLE and COMPUTE waits.
// expired flags the last allowed waiting cycle (count == 1).
module stage_timer
  import loop_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= W'(TIMEOUT_CYCLES);
    end else if (run && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = run && (count == W'(1));

endmodule

// File: rtl/loop_scheduler.sv
// Sequences one control-loop iteration per tick: sample, PID step,
// duty update and decimated telemetry logging, with timeout and overrun.
module loop_scheduler
  import loop_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned LOG_DECIMATION = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       clear_err,
  output logic       adc_req,
  input  logic       adc_valid,
  output logic       pid_start,
  input  logic       pid_done,
  output logic       duty_load,
  output logic       log_wr_en,
  input  logic       log_full,
  output logic       busy,
  output logic       overrun,
  output logic       timeout_err,
  output logic [7:0] drop_cnt
);

  localparam int DEC_W = (LOG_DECIMATION > 1) ? $clog2(LOG_DECIMATION) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(LOG_DECIMATION - 1);

  state_t           state, state_next;
  logic [DEC_W-1:0] dec_cnt, dec_cnt_next;
  logic             adc_req_next, pid_start_next, duty_load_next, log_wr_en_next;
  logic             timeout_next, drop_evt;
  logic             timer_load, timer_run, timer_expired;

  stage_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .run    (timer_run),
    .expired(timer_expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    dec_cnt_next   = dec_cnt;
    adc_req_next   = 1'b0;
    pid_start_next = 1'b0;
    duty_load_next = 1'b0;
    log_wr_en_next = 1'b0;
    timeout_next   = 1'b0;
    drop_evt       = 1'b0;

    if (state != IDLE && !enable) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (tick && enable) begin
          state_next   = SAMPLE;
          adc_req_next = 1'b1;
        end
        SAMPLE: if (adc_valid) begin
          state_next     = COMPUTE;
          pid_start_next = 1'b1;
        end else if (timer_expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
        COMPUTE: if (pid_done) begin
          state_next     = APPLY;
          duty_load_next = 1'b1;
        end else if (timer_expired) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
        APPLY: if (dec_cnt == DEC_LAST) begin
          // The FIFO is sampled on the way into LOG so the strobe is registered.
          dec_cnt_next   = '0;
          state_next     = LOG;
          log_wr_en_next = !log_full;
          drop_evt       = log_full;
        end else begin
          dec_cnt_next = dec_cnt + DEC_W'(1);
          state_next   = IDLE;
        end
        LOG:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    timer_run  = (state == SAMPLE) || (state == COMPUTE);
    timer_load = (state_next == SAMPLE  && state != SAMPLE) ||
                 (state_next == COMPUTE && state != COMPUTE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dec_cnt     <= '0;
      adc_req     <= 1'b0;
      pid_start   <= 1'b0;
      duty_load   <= 1'b0;
      log_wr_en   <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      state       <= state_next;
      dec_cnt     <= dec_cnt_next;
      adc_req     <= adc_req_next;
      pid_start   <= pid_start_next;
      duty_load   <= duty_load_next;
      log_wr_en   <= log_wr_en_next;
      busy        <= (state_next != IDLE);
      timeout_err <= timeout_next;

      // A new event outranks clear_err in the same cycle.
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end

      if (drop_evt) begin
        drop_cnt <= clear_err ? 8'd1 : sat_inc8(drop_cnt);
      end else if (clear_err) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_loop_scheduler.sv
// Self-checking bench for loop_scheduler: directed tables and sequences,
// then randomized traffic compared against a transaction-level model.
module tb_loop_scheduler;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset, tick, enable, clear_err, adc_valid, pid_done, log_full;
  logic       adc_req, pid_start, duty_load, log_wr_en, busy, overrun, timeout_err;
  logic [7:0] drop_cnt;
  logic       d4_adc_req, d4_pid_start, d4_duty_load, d4_log_wr_en, d4_busy;
  logic       d4_overrun, d4_timeout_err;
  logic [7:0] d4_drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  loop_scheduler #(.TIMEOUT_CYCLES(TO), .LOG_DECIMATION(1)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .clear_err(clear_err),
    .adc_req(adc_req), .adc_valid(adc_valid), .pid_start(pid_start),
    .pid_done(pid_done), .duty_load(duty_load), .log_wr_en(log_wr_en),
    .log_full(log_full), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .drop_cnt(drop_cnt)
  );

  loop_scheduler #(.TIMEOUT_CYCLES(TO), .LOG_DECIMATION(4)) u_dec (
    .clk(clk), .reset(reset), .tick(tick), .enable(enable), .clear_err(clear_err),
    .adc_req(d4_adc_req), .adc_valid(adc_valid), .pid_start(d4_pid_start),
    .pid_done(pid_done), .duty_load(d4_duty_load), .log_wr_en(d4_log_wr_en),
    .log_full(log_full), .busy(d4_busy), .overrun(d4_overrun),
    .timeout_err(d4_timeout_err), .drop_cnt(d4_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic       tick;
    logic       adc_valid;
    logic       pid_done;
    logic [6:0] exp;   // {adc_req, pid_start, duty_load, log_wr_en, busy, timeout_err, overrun}
  } vec_t;

  vec_t nom[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] outs();
    return {adc_req, pid_start, duty_load, log_wr_en, busy, timeout_err, overrun};
  endfunction

  function automatic logic [6:0] d4_outs();
    return {d4_adc_req, d4_pid_start, d4_duty_load, d4_log_wr_en, d4_busy,
            d4_timeout_err, d4_overrun};
  endfunction

  // One full loop with immediate sample and PID responses; counts log strobes.
  task automatic run_loop(output int logs1, output int logs4);
    int k;
    logs1 = 0;
    logs4 = 0;
    tick = 1'b1; step(); tick = 1'b0;
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    pid_done = 1'b1; step(); pid_done = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      logs1 += int'(log_wr_en);
      logs4 += int'(d4_log_wr_en);
      step();
      k++;
    end
    check("loop_returns_idle", busy, 0);
  endtask

  // Reference model: stage number, absolute deadline cycle, total loop count.
  int       m_stage, m_deadline, m_loops, m_drop;
  bit       m_ovr;
  bit [6:0] m_exp;

  task automatic model_step(input int cyc);
    bit req = 0, ps = 0, dl = 0, lw = 0, to = 0, drop = 0;
    int nxt = m_stage;
    if (reset) begin
      m_stage = 0; m_loops = 0; m_ovr = 0; m_drop = 0; m_exp = '0;
      return;
    end
    if (m_stage != 0 && !enable) nxt = 0;
    else begin
      case (m_stage)
        0: if (tick && enable) begin nxt = 1; req = 1; m_deadline = cyc + TO; end
        1: if (adc_valid) begin nxt = 2; ps = 1; m_deadline = cyc + TO; end
           else if (cyc == m_deadline) begin nxt = 0; to = 1; end
        2: if (pid_done) begin nxt = 3; dl = 1; end
           else if (cyc == m_deadline) begin nxt = 0; to = 1; end
        3: begin
          m_loops++;
          nxt = 0;
          if (m_loops % 1 == 0) begin
            nxt = 4;
            if (log_full) drop = 1; else lw = 1;
          end
        end
        default: nxt = 0;
      endcase
    end
    if (tick && m_stage != 0) m_ovr = 1;
    else if (clear_err) m_ovr = 0;
    if (drop) m_drop = clear_err ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    else if (clear_err) m_drop = 0;
    m_stage = nxt;
    m_exp = {req, ps, dl, lw, (nxt != 0), to, m_ovr};
  endtask

  initial begin
    int l1, l4, cnt_a, cnt_b, at;

    nom[0]  = '{1'b1, 1'b0, 1'b0, 7'b0000000};
    nom[1]  = '{1'b0, 1'b0, 1'b0, 7'b1000100};
    nom[2]  = '{1'b0, 1'b0, 1'b0, 7'b0000100};
    nom[3]  = '{1'b0, 1'b0, 1'b0, 7'b0000100};
    nom[4]  = '{1'b0, 1'b0, 1'b0, 7'b0000100};
    nom[5]  = '{1'b0, 1'b1, 1'b0, 7'b0000100};
    nom[6]  = '{1'b0, 1'b0, 1'b0, 7'b0100100};
    nom[7]  = '{1'b0, 1'b0, 1'b0, 7'b0000100};
    nom[8]  = '{1'b0, 1'b0, 1'b0, 7'b0000100};
    nom[9]  = '{1'b0, 1'b0, 1'b1, 7'b0000100};
    nom[10] = '{1'b0, 1'b0, 1'b0, 7'b0010100};
    nom[11] = '{1'b0, 1'b0, 1'b0, 7'b0001100};
    nom[12] = '{1'b0, 1'b0, 1'b0, 7'b0000000};

    // Reset held against active inputs: no pulse may leak out.
    reset = 1'b1; enable = 1'b1; tick = 1'b1; adc_valid = 1'b1; pid_done = 1'b1;
    clear_err = 1'b0; log_full = 1'b0;
    step();
    check("reset_outs", outs(), 0);
    check("reset_drop", drop_cnt, 0);
    check("reset_d4_outs", d4_outs(), 0);
    step();
    check("reset_hold_outs", outs(), 0);
    reset = 1'b0; tick = 1'b0; adc_valid = 1'b0; pid_done = 1'b0;
    step();
    check("post_reset_outs", outs(), 0);

    // Nominal loop, table-driven, cycle 0 = tick.
    for (int i = 0; i < 13; i++) begin
      check($sformatf("nominal_c%0d", i), outs(), nom[i].exp);
      tick = nom[i].tick; adc_valid = nom[i].adc_valid; pid_done = nom[i].pid_done;
      step();
    end

    // Sample timeout: entry at cycle 1, pulse expected at cycle 11.
    tick = 1'b1; step(); tick = 1'b0;
    cnt_a = 0; cnt_b = 0; at = -1;
    for (int c = 1; c <= 14; c++) begin
      if (timeout_err) begin cnt_a++; at = c; end
      cnt_b += int'(pid_start);
      if (c == 11) check("timeout_busy_low", busy, 0);
      step();
    end
    check("timeout_pulses", cnt_a, 1);
    check("timeout_cycle", at, 11);
    check("timeout_no_pid_start", cnt_b, 0);

    // adc_valid in the expiry cycle beats the timeout.
    tick = 1'b1; step(); tick = 1'b0;
    repeat (9) step();
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    check("prio_pid_start", pid_start, 1);
    check("prio_no_timeout", timeout_err, 0);
    pid_done = 1'b1; step(); pid_done = 1'b0;
    check("prio_duty_load", duty_load, 1);
    step(); step();
    check("prio_idle", busy, 0);

    // Second tick during COMPUTE: overrun, nothing queued.
    tick = 1'b1; step(); tick = 1'b0;
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    check("overrun_set", overrun, 1);
    cnt_a = int'(adc_req);
    pid_done = 1'b1; step(); pid_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cnt_a += int'(adc_req);
      step();
    end
    check("overrun_no_extra_req", cnt_a, 0);
    check("overrun_idle", busy, 0);

    // FIFO full for three loops.
    log_full = 1'b1;
    cnt_a = 0;
    for (int n = 0; n < 3; n++) begin
      run_loop(l1, l4);
      cnt_a += l1;
    end
    check("drop_no_log_wr", cnt_a, 0);
    check("drop_cnt_3", drop_cnt, 3);
    check("overrun_sticky", overrun, 1);

    // Drop and clear_err in the same cycle: the drop wins.
    tick = 1'b1; step(); tick = 1'b0;
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    pid_done = 1'b1; step(); pid_done = 1'b0;
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("drop_beats_clear", drop_cnt, 1);
    check("clear_overrun_same", overrun, 0);
    step();
    log_full = 1'b0;
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("clear_drop", drop_cnt, 0);

    // Tick during SAMPLE together with clear_err: overrun wins.
    tick = 1'b1; step();
    clear_err = 1'b1; step(); tick = 1'b0; clear_err = 1'b0;
    check("overrun_beats_clear", overrun, 1);
    check("tick_not_queued", adc_req, 0);

    // Enable dropped in SAMPLE, then a late adc_valid.
    enable = 1'b0; step();
    check("abort_idle", busy, 0);
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    pid_done = 1'b1; step(); pid_done = 1'b0;
    cnt_a = 0;
    for (int c = 0; c < 4; c++) begin
      cnt_a += int'(pid_start) + int'(duty_load) + int'(busy);
      step();
    end
    check("abort_no_pulses", cnt_a, 0);
    enable = 1'b1;
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("clear_overrun", overrun, 0);

    // Reset in COMPUTE together with pid_done.
    tick = 1'b1; step(); tick = 1'b0;
    adc_valid = 1'b1; step(); adc_valid = 1'b0;
    check("rst_mid_in_compute", busy, 1);
    reset = 1'b1; pid_done = 1'b1; step(); reset = 1'b0; pid_done = 1'b0;
    check("rst_mid_outs", outs(), 0);
    check("rst_mid_drop", drop_cnt, 0);
    cnt_a = 0;
    for (int c = 0; c < 4; c++) begin
      cnt_a += int'(duty_load) + int'(busy);
      step();
    end
    check("rst_mid_no_duty", cnt_a, 0);

    // Decimation by four on the second instance.
    reset = 1'b1; step(); reset = 1'b0; step();
    cnt_b = 0;
    for (int n = 1; n <= 8; n++) begin
      run_loop(l1, l4);
      cnt_b += l4;
      check($sformatf("decim_loop%0d", n), l4, (n % 4 == 0) ? 1 : 0);
    end
    check("decim_total", cnt_b, 2);

    // drop_cnt saturates at 255.
    log_full = 1'b1;
    for (int n = 0; n < 257; n++) run_loop(l1, l4);
    check("drop_saturate", drop_cnt, 255);
    log_full = 1'b0;

    // Randomized traffic against the reference model.
    reset = 1'b1;
    model_step(0);
    step();
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      check($sformatf("rand_outs_c%0d", cyc), outs(), m_exp);
      check($sformatf("rand_drop_c%0d", cyc), drop_cnt, m_drop);
      reset     = ($urandom_range(255) == 0);
      tick      = ($urandom_range(5) == 0);
      enable    = ($urandom_range(39) != 0);
      adc_valid = ($urandom_range(4) == 0);
      pid_done  = ($urandom_range(4) == 0);
      log_full  = ($urandom_range(2) == 0);
      clear_err = ($urandom_range(19) == 0);
      model_step(cyc);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_scheduler.md
LOOP_SCHEDULER -- requirements
Module: loop_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000; max cycles spent waiting in SAMPLE or COMPUTE.
REQ-002 SHALL have parameter LOG_DECIMATION, default 1; one log write per N completed loops (N>=1).
REQ-003 SHALL have port clk  in  1  system clock; one clock domain only.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tick  in  1  one-cycle control-loop clock-enable pulse (32 Hz).
REQ-006 SHALL have port enable  in  1  motor enable; loop runs only while high.
REQ-007 SHALL have port clear_err  in  1  clears overrun and drop_cnt.
REQ-008 SHALL have port adc_req  out  1  one-cycle pulse requesting a fresh distance sample.
REQ-009 SHALL have port adc_valid  in  1  sample ready; single-cycle pulse.
REQ-010 SHALL have port pid_start  out  1  one-cycle pulse starting one PID step.
REQ-011 SHALL have port pid_done  in  1  PID output valid; single-cycle pulse.
REQ-012 SHALL have port duty_load  out  1  one-cycle pulse loading new duty-cycle registers.
REQ-013 SHALL have port log_wr_en  out  1  one-cycle telemetry FIFO write strobe.
REQ-014 SHALL have port log_full  in  1  telemetry FIFO full.
REQ-015 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-016 SHALL have port overrun  out  1  sticky; a tick arrived while busy.
REQ-017 SHALL have port timeout_err  out  1  one-cycle pulse on stage timeout.
REQ-018 SHALL have port drop_cnt  out  8  saturating count of log writes skipped because of FIFO full.

Function
REQ-019 SHALL implement the states IDLE, SAMPLE, COMPUTE, APPLY and LOG; all outputs SHALL be registered.
REQ-020 SHALL, in IDLE with tick & enable at cycle T, enter SAMPLE and assert adc_req at T+1 only.
REQ-021 SHALL, in SAMPLE, on adc_valid at cycle V, enter COMPUTE and assert pid_start at V+1.
REQ-022 SHALL, in COMPUTE, on pid_done at cycle D, enter APPLY and assert duty_load at D+1.
REQ-023 SHALL spend exactly one cycle in APPLY, then enter LOG when the decimation count equals LOG_DECIMATION-1 (the count then wraps to 0), else increment the count and return to IDLE.
REQ-024 SHALL, in LOG (cycle D+2), assert log_wr_en for one cycle when log_full=0; otherwise it SHALL increment drop_cnt (saturating at 255); both cases SHALL return to IDLE.
REQ-025 SHALL load the stage timer with TIMEOUT_CYCLES on entry to SAMPLE and COMPUTE; on expiry it SHALL pulse timeout_err and return to IDLE without issuing further pulses.
REQ-026 SHALL give adc_valid or pid_done priority over timeout expiry in the same cycle.
REQ-027 SHALL accept tick only in IDLE; a tick in any other state SHALL set overrun and SHALL otherwise be ignored (not queued).
REQ-028 SHALL, when enable falls mid-sequence, return to IDLE on the next cycle with no further adc_req, pid_start, duty_load or log_wr_en; the decimation count SHALL be preserved.
REQ-029 SHALL ignore adc_valid and pid_done outside SAMPLE and COMPUTE respectively.
REQ-030 SHALL, on clear_err, clear overrun and drop_cnt; an event in the same cycle as clear_err SHALL win.

Reset
REQ-031 SHALL, on reset, set state to IDLE and clear every output, the decimation count and the stage timer to 0.
REQ-032 SHALL give reset priority over all inputs, including in mid-sequence; no pulse SHALL be emitted in the cycle after reset.

Structure
REQ-033 SHALL declare the state enum and the default TIMEOUT_CYCLES constant in the shared package loop_sched_pkg.
REQ-034 SHALL place the timer in sub-module stage_timer (loadable down-counter with expiry flag, width $clog2(TIMEOUT_CYCLES+1)).

Verification
REQ-035 SHALL verify the nominal path: enable=1, tick@0, adc_valid@5, pid_done@9 -> adc_req@1, pid_start@6, duty_load@10, log_wr_en@11, busy low @12.
REQ-036 SHALL verify timeout: TIMEOUT_CYCLES=10, no adc_valid -> timeout_err one pulse at entry+10, IDLE, no pid_start.
REQ-037 SHALL verify overrun and FIFO drop: second tick during COMPUTE -> overrun=1 and no extra adc_req; log_full=1 for 3 loops -> drop_cnt=3, no log_wr_en; clear_err -> both 0.
REQ-038 SHALL verify decimation: LOG_DECIMATION=4, 8 complete loops -> exactly 2 log_wr_en pulses, on loops 4 and 8.
REQ-039 SHALL verify abort: enable dropped in SAMPLE, then adc_valid -> IDLE next cycle, no pid_start or duty_load.
REQ-040 SHALL verify reset mid-COMPUTE plus pid_done -> all outputs 0, no duty_load.
